// File: rtl/wb_kv_initiator.sv
// Wishbone classic single-transfer initiator: takes one command on a valid/ready
// port, runs one CYC/STB cycle with a bus timeout, and returns data or an error.
module wb_kv_initiator #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_adr,
  input  logic [DATA_W-1:0]     cmd_dat,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic                  rsp_err,
  output logic                  CYC_o,
  output logic                  STB_o,
  output logic                  WE_o,
  output logic [DATA_W/8-1:0]   SEL_o,
  output logic [ADDR_W-1:0]     ADR_o,
  output logic [DATA_W-1:0]     DAT_o,
  input  logic                  ACK_i,
  input  logic [DATA_W-1:0]     DAT_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  cyc_nxt, stb_nxt, we_nxt;
  logic [DATA_W/8-1:0]   sel_nxt;
  logic [ADDR_W-1:0]     adr_nxt;
  logic [DATA_W-1:0]     dat_nxt;
  logic                  rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0]     rsp_dat_nxt;

  assign cmd_ready = (state == IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cyc_nxt       = CYC_o;
    stb_nxt       = STB_o;
    we_nxt        = WE_o;
    sel_nxt       = SEL_o;
    adr_nxt       = ADR_o;
    dat_nxt       = DAT_o;
    rsp_valid_nxt = rsp_valid;
    rsp_dat_nxt   = rsp_dat;
    rsp_err_nxt   = rsp_err;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = cmd_we;
          sel_nxt   = '1;
          adr_nxt   = cmd_adr;
          dat_nxt   = cmd_dat;
          cnt_nxt   = '0;
          state_nxt = BUS;
        end
      end
      BUS: begin
        // ACK is checked first so an ACK on the final allowed cycle still wins.
        if (ACK_i || cnt == CNT_LAST) begin
          cyc_nxt       = 1'b0;
          stb_nxt       = 1'b0;
          we_nxt        = 1'b0;
          sel_nxt       = '0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = ~ACK_i;
          rsp_dat_nxt   = (ACK_i && !WE_o) ? DAT_i : '0;
          state_nxt     = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      CYC_o     <= 1'b0;
      STB_o     <= 1'b0;
      WE_o      <= 1'b0;
      SEL_o     <= '0;
      ADR_o     <= '0;
      DAT_o     <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      CYC_o     <= cyc_nxt;
      STB_o     <= stb_nxt;
      WE_o      <= we_nxt;
      SEL_o     <= sel_nxt;
      ADR_o     <= adr_nxt;
      DAT_o     <= dat_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_dat   <= rsp_dat_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_kv_initiator.sv
// Directed bench for wb_kv_initiator: transaction-level expectations are compared
// against the DUT on every falling edge, plus literal checks per transfer.
module tb_wb_kv_initiator;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic            cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0]   cmd_adr;
  logic [DW-1:0]   cmd_dat;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]   rsp_dat;
  logic            CYC_o, STB_o, WE_o;
  logic [DW/8-1:0] SEL_o;
  logic [AW-1:0]   ADR_o;
  logic [DW-1:0]   DAT_o;
  logic            ACK_i;
  logic [DW-1:0]   DAT_i;

  always #5 sys_clk = ~sys_clk;

  wb_kv_initiator #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .CYC_o(CYC_o), .STB_o(STB_o), .WE_o(WE_o), .SEL_o(SEL_o),
    .ADR_o(ADR_o), .DAT_o(DAT_o), .ACK_i(ACK_i), .DAT_i(DAT_i)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Expected outputs for the current cycle, set by the transaction driver.
  logic            check_en = 1'b0;
  logic            e_rdy, e_cyc, e_stb, e_we, e_rv, e_rerr;
  logic [DW/8-1:0] e_sel;
  logic [AW-1:0]   e_adr;
  logic [DW-1:0]   e_dat, e_rdat;

  int unsigned     stb_seen;
  logic [DW-1:0]   last_rdat;
  logic            last_rerr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    e_rdy = 1'b1; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_rv = 1'b0;
  endtask

  task automatic set_bus(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    e_rdy = 1'b0; e_cyc = 1'b1; e_stb = 1'b1; e_we = we; e_sel = '1;
    e_adr = adr; e_dat = dat; e_rv = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    if (check_en) begin
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("CYC_o", CYC_o, e_cyc);
      chk("STB_o", STB_o, e_stb);
      chk("WE_o", WE_o, e_we);
      chk("SEL_o", SEL_o, e_sel);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_stb) begin
        chk("ADR_o", ADR_o, e_adr);
        chk("DAT_o", DAT_o, e_dat);
      end
      if (e_rv) begin
        chk("rsp_dat", rsp_dat, e_rdat);
        chk("rsp_err", rsp_err, e_rerr);
      end
    end
    if (STB_o) stb_seen++;
    if (rsp_valid) begin
      last_rdat = rsp_dat;
      last_rerr = rsp_err;
    end
  end

  // One whole transfer. ack_at: BUS cycle (1-based) on which the slave ACKs;
  // 0 or beyond TO means it never does. ready_delay: RESP cycles with rsp_ready=0.
  task automatic xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input int unsigned ack_at, input logic [DW-1:0] rdata,
                      input int unsigned ready_delay, input logic hold_cmd);
    logic acked;
    int unsigned nstb;
    acked = (ack_at >= 1) && (ack_at <= TO);
    nstb  = acked ? ack_at : TO;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
    stb_seen = 0;
    set_idle();
    @(posedge sys_clk) #1;
    for (int unsigned i = 1; i <= nstb; i++) begin
      cmd_valid = hold_cmd; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom;
      set_bus(we, adr, dat);
      ACK_i = acked && (i == nstb);
      DAT_i = ACK_i ? rdata : DW'($urandom);
      @(posedge sys_clk) #1;
    end
    e_rdy = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_sel = '0; e_rv = 1'b1;
    e_rdat = (acked && !we) ? rdata : '0;
    e_rerr = ~acked;
    for (int unsigned j = 0; j <= ready_delay; j++) begin
      rsp_ready = (j == ready_delay);
      ACK_i = ~acked && (j == 0);
      DAT_i = $urandom;
      @(posedge sys_clk) #1;
    end
    rsp_ready = 1'b0; ACK_i = 1'b0; cmd_valid = 1'b0;
    set_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    rsp_ready = 1'b0; ACK_i = 1'b0; DAT_i = '0;
    #12;
    chk("rst_cyc", CYC_o, 0);
    chk("rst_stb", STB_o, 0);
    chk("rst_sel", SEL_o, 0);
    chk("rst_adr", ADR_o, 0);
    chk("rst_dat", DAT_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    @(posedge sys_clk) #1;
    set_idle();
    check_en = 1'b1;

    // Write, ACK on second BUS cycle
    xfer(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 2, 32'h1234_5678, 0, 1'b0);
    chk("wr_stb_len", stb_seen, 2);
    chk("wr_rsp_dat", last_rdat, 32'h0);
    chk("wr_rsp_err", last_rerr, 0);

    // Read, immediate ACK
    xfer(1'b0, 32'h3001_0000, 32'hFFFF_FFFF, 1, 32'h0000_0001, 0, 1'b0);
    chk("rd_stb_len", stb_seen, 1);
    chk("rd_rsp_dat", last_rdat, 32'h1);
    chk("rd_rsp_err", last_rerr, 0);

    // Timeout with a late ACK during RESP
    xfer(1'b0, 32'h3002_0000, 32'h0, 0, 32'h5555_5555, 2, 1'b0);
    chk("to_stb_len", stb_seen, 4);
    chk("to_rsp_dat", last_rdat, 32'h0);
    chk("to_rsp_err", last_rerr, 1);

    // ACK on the last allowed cycle
    xfer(1'b0, 32'h3003_0000, 32'h0, 4, 32'hCAFE_F00D, 0, 1'b0);
    chk("edge_stb_len", stb_seen, 4);
    chk("edge_rsp_dat", last_rdat, 32'hCAFE_F00D);
    chk("edge_rsp_err", last_rerr, 0);

    // Backpressure with a pending command
    xfer(1'b0, 32'h3004_0000, 32'h0, 3, 32'hA5A5_5A5A, 5, 1'b1);
    chk("bp_stb_len", stb_seen, 3);
    chk("bp_rsp_dat", last_rdat, 32'hA5A5_5A5A);

    // Back-to-back minimum-latency transfers
    xfer(1'b1, 32'h3005_0004, 32'h0BAD_F00D, 1, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h3005_0008, 32'h0, 1, 32'h7777_8888, 0, 1'b0);
    chk("b2b_rsp_dat", last_rdat, 32'h7777_8888);

    // Reset asserted while STB_o is high
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3006_0000; cmd_dat = '0;
    @(posedge sys_clk) #1;
    cmd_valid = 1'b0;
    set_bus(1'b0, 32'h3006_0000, 32'h0);
    @(posedge sys_clk) #1;
    check_en = 1'b0;
    chk("pre_rst_stb", STB_o, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst_cyc", CYC_o, 0);
    chk("midrst_stb", STB_o, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk) #1;
    chk("postrst_cmd_ready", cmd_ready, 1);
    chk("postrst_rsp_valid", rsp_valid, 0);
    chk("postrst_cyc", CYC_o, 0);
    set_idle();
    check_en = 1'b1;

    xfer(1'b0, 32'h3007_0000, 32'h0, 2, 32'h0000_00C3, 1, 1'b0);
    chk("recov_rsp_dat", last_rdat, 32'hC3);
    @(posedge sys_clk) #1;
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
